// File: rtl/mem_responder_if.sv
// CPU memory bus between the cpu (master) and mem_responder (slave).
// Four-phase req/ack handshake carrying 64-bit data plus an 8-bit tag.
`timescale 1ns/1ps
interface mem_responder_if #(
  parameter int ADDR_W = 15
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic [7:0]        wtag;
  logic              ack;
  logic [63:0]       rdata;
  logic [7:0]        rtag;
  logic              err;

  modport master (
    output req, we, addr, wdata, wtag,
    input  ack, rdata, rtag, err
  );

  modport slave (
    input  req, we, addr, wdata, wtag,
    output ack, rdata, rtag, err
  );
endinterface

// File: rtl/mem_responder.sv
// Responder end of the CPU memory bus: word array answered after WAIT_STATES cycles.
// Optional MEM_ERR_EN: out-of-range addresses complete with err=1 instead of wrapping.
`timescale 1ns/1ps
module mem_responder #(
  parameter int    ADDR_W      = 15,
  parameter int    DEPTH       = 4096,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  typedef struct packed {
    logic             we;
    logic             oor;
    logic [IDX_W-1:0] idx;
    logic [63:0]      wdata;
    logic [7:0]       wtag;
  } req_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        cap_q, cap_d;
  logic [63:0] rdata_q, rdata_d;
  logic [7:0]  rtag_q, rtag_d;
  logic        err_q, err_d;

  // Each word holds {tag, data}.
  logic [71:0] mem [DEPTH];
  logic [71:0] mem_rd;
  logic        mem_we;

  // ---------------------------------------------------------------------------
  // Address decode at capture time
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0]  addr_ext;
  logic [IDX_W-1:0] idx_in;
  logic             oor_in;

  assign addr_ext = {1'b0, bus.addr};

`ifdef MEM_ERR_EN
  assign oor_in = (addr_ext >= DEPTH_W);
  assign idx_in = IDX_W'(bus.addr);
`else
  // Constant modulus: reduces to a bit-select when DEPTH is a power of two.
  assign oor_in = 1'b0;
  assign idx_in = IDX_W'(addr_ext % DEPTH_W);
`endif

  assign mem_rd = mem[cap_q.idx];

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    rtag_d  = rtag_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          cap_d.we    = bus.we;
          cap_d.oor   = oor_in;
          cap_d.idx   = idx_in;
          cap_d.wdata = bus.wdata;
          cap_d.wtag  = bus.wtag;
          cnt_d       = 4'(WAIT_STATES);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (!bus.req) begin
          // Master withdrew mid-access: abandon without touching the array.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          mem_we  = cap_q.we && !cap_q.oor;
          state_d = DONE;
          if (cap_q.oor) begin
            rdata_d = '0;
            rtag_d  = '0;
            err_d   = 1'b1;
          end else if (cap_q.we) begin
            rdata_d = cap_q.wdata;
            rtag_d  = cap_q.wtag;
            err_d   = 1'b0;
          end else begin
            rdata_d = mem_rd[63:0];
            rtag_d  = mem_rd[71:64];
            err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!bus.req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      rtag_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; mem_we comes from reset flops so reset blocks any commit.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cap_q.idx] <= {cap_q.wtag, cap_q.wdata};
  end

  // err_q can only be set via oor, which is constant 0 without MEM_ERR_EN.
  assign bus.ack   = (state_q == DONE);
  assign bus.rdata = rdata_q;
  assign bus.rtag  = rtag_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_STATES=2 instance (b2) and WAIT_STATES=0 instance (b0).
`timescale 1ns/1ps
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(15)) b2 ();
  mem_responder_if #(.ADDR_W(15)) b0 ();

  mem_responder #(.ADDR_W(15), .DEPTH(4096), .WAIT_STATES(2), .INIT_FILE("")) dut2 (
    .clk(clk), .reset(reset), .bus(b2));
  mem_responder #(.ADDR_W(15), .DEPTH(4096), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .bus(b0));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Full handshake on b2; inputs are scrambled while ack is held to prove they are ignored.
  task automatic txn2(input logic w, input logic [14:0] a, input logic [63:0] d,
                      input logic [7:0] t, input int hold, output int lat,
                      output logic [63:0] rd, output logic [7:0] rt, output logic e,
                      output logic held, output logic fell);
    @(posedge clk); #1;
    b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d; b2.wtag = t;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b2.ack) begin lat = i; break; end
    end
    rd = b2.rdata; rt = b2.rtag; e = b2.err; held = (lat >= 0);
    b2.we = ~w; b2.addr = a + 15'd1; b2.wdata = ~d; b2.wtag = ~t;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!b2.ack || b2.rdata !== rd || b2.rtag !== rt) held = 1'b0;
    end
    b2.req = 1'b0;
    @(posedge clk); #1;
    fell = !b2.ack;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 15'd1; b2.wdata = 64'h55; b2.wtag = 8'h5;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0; b0.wtag = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (b2.ack !== 1'b0) begin failures++; $display("FAIL reset_ack cyc%0d: got %b expected 0", i, b2.ack); end
      checks++; if (b2.rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata cyc%0d: got %h expected 0", i, b2.rdata); end
      checks++; if (b2.err !== 1'b0) begin failures++; $display("FAIL reset_err cyc%0d: got %b expected 0", i, b2.err); end
    end
    checks++; if (b0.rtag !== 8'h0) begin failures++; $display("FAIL reset_rtag: got %h expected 0", b0.rtag); end
    b2.req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (b2.ack !== 1'b0) begin failures++; $display("FAIL reset_release_ack: got %b expected 0", b2.ack); end
  endtask

  task automatic test_write_read();
    int lat; logic [63:0] rd; logic [7:0] rt; logic e, held, fell;
    txn2(1'b1, 15'd5, 64'h0123_4567_89AB_CDEF, 8'h3C, 0, lat, rd, rt, e, held, fell);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL wr_echo_data: got %h expected 0123456789abcdef", rd); end
    checks++; if (rt !== 8'h3C) begin failures++; $display("FAIL wr_echo_tag: got %h expected 3c", rt); end
    checks++; if (fell !== 1'b1) begin failures++; $display("FAIL wr_ack_fall: got %b expected 1", fell); end
    txn2(1'b0, 15'd5, 64'h0, 8'h0, 3, lat, rd, rt, e, held, fell);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL rd_data: got %h expected 0123456789abcdef", rd); end
    checks++; if (rt !== 8'h3C) begin failures++; $display("FAIL rd_tag: got %h expected 3c", rt); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL rd_err: got %b expected 0", e); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL rd_ack_held: got %b expected 1", held); end
    checks++; if (fell !== 1'b1) begin failures++; $display("FAIL rd_ack_fall: got %b expected 1", fell); end
  endtask

  task automatic test_abort();
    int lat; logic [63:0] rd; logic [7:0] rt; logic e, held, fell, quiet;
    txn2(1'b1, 15'd7, 64'h1, 8'h11, 0, lat, rd, rt, e, held, fell);
    @(posedge clk); #1;
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 15'd7; b2.wdata = 64'hDEAD; b2.wtag = 8'hEE;
    @(posedge clk); #1;
    b2.req = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (b2.ack) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL abort_no_ack: got %b expected 1", quiet); end
    txn2(1'b0, 15'd7, 64'h0, 8'h0, 0, lat, rd, rt, e, held, fell);
    checks++; if (lat !== 3) begin failures++; $display("FAIL abort_rd_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 64'h1) begin failures++; $display("FAIL abort_rd_data: got %h expected 1", rd); end
    checks++; if (rt !== 8'h11) begin failures++; $display("FAIL abort_rd_tag: got %h expected 11", rt); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [63:0] rd; logic [7:0] rt; logic e, held, fell;
    txn2(1'b1, 15'd4, 64'hAAAA_0000_0000_0004, 8'h44, 0, lat, rd, rt, e, held, fell);
    txn2(1'b1, 15'd4100, 64'hBBBB_0000_0000_1004, 8'h99, 0, lat, rd, rt, e, held, fell);
`ifdef MEM_ERR_EN
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_wr_err: got %b expected 1", e); end
    checks++; if (rd !== 64'h0) begin failures++; $display("FAIL oor_wr_rdata: got %h expected 0", rd); end
    txn2(1'b0, 15'd4100, 64'h0, 8'h0, 0, lat, rd, rt, e, held, fell);
    checks++; if (e !== 1'b1 || rd !== 64'h0 || rt !== 8'h0) begin failures++; $display("FAIL oor_rd: got err=%b data=%h tag=%h expected err=1 data=0 tag=0", e, rd, rt); end
    txn2(1'b0, 15'd4, 64'h0, 8'h0, 0, lat, rd, rt, e, held, fell);
    checks++; if (rd !== 64'hAAAA_0000_0000_0004) begin failures++; $display("FAIL oor_addr4_kept: got %h expected aaaa000000000004", rd); end
`else
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL wrap_wr_err: got %b expected 0", e); end
    checks++; if (rd !== 64'hBBBB_0000_0000_1004) begin failures++; $display("FAIL wrap_wr_echo: got %h expected bbbb000000001004", rd); end
    txn2(1'b0, 15'd4100, 64'h0, 8'h0, 0, lat, rd, rt, e, held, fell);
    checks++; if (e !== 1'b0 || rd !== 64'hBBBB_0000_0000_1004) begin failures++; $display("FAIL wrap_rd: got err=%b data=%h expected err=0 data=bbbb000000001004", e, rd); end
    txn2(1'b0, 15'd4, 64'h0, 8'h0, 0, lat, rd, rt, e, held, fell);
    checks++; if (rd !== 64'hBBBB_0000_0000_1004 || rt !== 8'h99) begin failures++; $display("FAIL wrap_addr4: got %h/%h expected bbbb000000001004/99", rd, rt); end
`endif
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL inrange_err: got %b expected 0", e); end
  endtask

  task automatic test_back_to_back();
    int lat, cap, prev_cap;
    logic [63:0] exp_d;
    prev_cap = 0;
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) begin
      exp_d = 64'hB0B0_0000_0000_0000 | 64'(j % 4);
      b0.req = 1'b1; b0.we = (j < 4); b0.addr = 15'(j % 4);
      b0.wdata = (j < 4) ? exp_d : 64'hFFFF; b0.wtag = 8'hA0 + 8'(j % 4);
      @(posedge clk); #1;
      cap = cyc;
      lat = -1;
      for (int k = 1; k < 10; k++) begin
        @(posedge clk); #1;
        if (b0.ack) begin lat = k; break; end
      end
      checks++; if (lat !== 1) begin failures++; $display("FAIL b2b_latency[%0d]: got %0d expected 1", j, lat); end
      if (j >= 4) begin
        checks++;
        if (b0.rdata !== exp_d || b0.rtag !== 8'hA0 + 8'(j % 4)) begin
          failures++; $display("FAIL b2b_rd[%0d]: got %h/%h expected %h/%h", j, b0.rdata, b0.rtag, exp_d, 8'hA0 + 8'(j % 4));
        end
      end
      if (j > 0) begin
        checks++; if (cap - prev_cap !== 3) begin failures++; $display("FAIL b2b_period[%0d]: got %0d expected 3", j, cap - prev_cap); end
      end
      prev_cap = cap;
      b0.req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_done();
    int lat; logic [63:0] rd; logic [7:0] rt; logic e, held, fell, seen;
    @(posedge clk); #1;
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 15'd9; b2.wdata = 64'h9999_8888_7777_6666; b2.wtag = 8'h69;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b2.ack) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rstdone_ack_seen: got %b expected 1", seen); end
    #3 reset = 1'b0;
    #1;
    checks++; if (b2.ack !== 1'b0) begin failures++; $display("FAIL rstdone_async_ack: got %b expected 0", b2.ack); end
    checks++; if (b2.rdata !== 64'h0) begin failures++; $display("FAIL rstdone_async_rdata: got %h expected 0", b2.rdata); end
    b2.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    txn2(1'b0, 15'd9, 64'h0, 8'h0, 0, lat, rd, rt, e, held, fell);
    checks++; if (rd !== 64'h9999_8888_7777_6666 || rt !== 8'h69) begin failures++; $display("FAIL rstdone_persist: got %h/%h expected 9999888877776666/69", rd, rt); end
    // Reset while BUSY must suppress the pending write.
    @(posedge clk); #1;
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 15'd9; b2.wdata = 64'hBAD; b2.wtag = 8'hBD;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (b2.ack !== 1'b0) begin failures++; $display("FAIL rstbusy_ack: got %b expected 0", b2.ack); end
    b2.req = 1'b0;
    reset = 1'b1;
    txn2(1'b0, 15'd9, 64'h0, 8'h0, 0, lat, rd, rt, e, held, fell);
    checks++; if (rd !== 64'h9999_8888_7777_6666) begin failures++; $display("FAIL rstbusy_no_write: got %h expected 9999888877776666", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
